// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared constants and receiver state encoding for the PS/2 keyboard receiver.
package ps2_kbd_ctrl_pkg;

    localparam int unsigned KbWidth    = 8;
    localparam int unsigned FrameLen   = 11;
    localparam int unsigned DefTimeout = 20000;

    typedef enum logic [1:0] {
        RxIdle  = 2'd0,
        RxRecv  = 2'd1,
        RxCheck = 2'd2
    } rxState_t;

    // Odd parity across data plus parity bit, framed by start=0 and stop=1.
    function automatic logic frameValid(input logic [FrameLen-1:0] frame);
        return (frame[0] == 1'b0) && (frame[FrameLen-1] == 1'b1)
            && ((^frame[KbWidth:1] ^ frame[FrameLen-2]) == 1'b1);
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Parameterised synchronous FIFO; head is read combinationally, zero when empty.
module kbd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wrPtr;
    logic [PtrW-1:0]  rdPtr;
    logic             doPush;
    logic             doPop;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AddrW] != rdPtr[AddrW])
                 && (wrPtr[AddrW-1:0] == rdPtr[AddrW-1:0]);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign head   = empty ? '0 : mem[rdPtr[AddrW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr[AddrW-1:0]] <= pushData;
                wrPtr                 <= wrPtr + PtrW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PtrW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver: synchronises the pad lines, deframes 11-bit frames and queues good scancodes.
module ps2_kbd_ctrl
    import ps2_kbd_ctrl_pkg::*;
#(
    parameter int unsigned KB_WIDTH   = KbWidth,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = DefTimeout
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    input  logic                sig_rd_kb,
    output logic [KB_WIDTH-1:0] kb_rdata,
    output logic                kb_ready,
    output logic                overflow,
    output logic                frame_err
);

    localparam int unsigned FrmW = KB_WIDTH + 3;
    localparam int unsigned CntW = $clog2(FrmW);
    localparam int unsigned ToW  = $clog2(TIMEOUT);

    logic [1:0]      clkSync;
    logic [1:0]      dataSync;
    logic            prevClk;
    logic            syncClk;
    logic            syncData;
    logic            fall;

    rxState_t        state;
    rxState_t        stateNext;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cntNext;
    logic [ToW-1:0]  toCnt;
    logic [ToW-1:0]  toCntNext;
    logic [FrmW-2:0] frame;
    logic [FrmW-2:0] frameNext;
    logic [FrmW-1:0] shifted;
    logic            frameOk;
    logic            frameOkNext;
    logic            frameErrNext;

    logic            fifoPush;
    logic            fifoFull;
    logic            fifoEmpty;

    assign syncClk  = clkSync[1];
    assign syncData = dataSync[1];
    assign fall     = prevClk && !syncClk;
    // Frame register holds the previous samples; the newest bit enters at the top.
    assign shifted  = {syncData, frame};

    always_ff @(posedge clk) begin
        if (rst) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
            prevClk  <= 1'b1;
        end else begin
            clkSync  <= {clkSync[0], ps2_clk};
            dataSync <= {dataSync[0], ps2_data};
            prevClk  <= syncClk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RxIdle;
            cnt       <= '0;
            toCnt     <= '0;
            frame     <= '0;
            frameOk   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            toCnt     <= toCntNext;
            frame     <= frameNext;
            frameOk   <= frameOkNext;
            frame_err <= frameErrNext;
        end
    end

    // Validity is resolved on the stop-bit edge so frame_err lands in the CHECK cycle.
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        toCntNext    = toCnt;
        frameNext    = frame;
        frameOkNext  = 1'b0;
        frameErrNext = 1'b0;
        case (state)
            RxIdle: begin
                toCntNext = '0;
                if (fall && !syncData) begin
                    frameNext = shifted[FrmW-1:1];
                    cntNext   = CntW'(1);
                    stateNext = RxRecv;
                end
            end
            RxRecv: begin
                if (fall) begin
                    frameNext = shifted[FrmW-1:1];
                    toCntNext = '0;
                    if (cnt == CntW'(FrmW - 1)) begin
                        cntNext      = '0;
                        stateNext    = RxCheck;
                        frameOkNext  = frameValid(shifted);
                        frameErrNext = !frameValid(shifted);
                    end else begin
                        cntNext = cnt + CntW'(1);
                    end
                end else if (toCnt == ToW'(TIMEOUT - 1)) begin
                    cntNext      = '0;
                    toCntNext    = '0;
                    stateNext    = RxIdle;
                    frameErrNext = 1'b1;
                end else begin
                    toCntNext = toCnt + ToW'(1);
                end
            end
            RxCheck: begin
                stateNext = RxIdle;
            end
            default: begin
                stateNext = RxIdle;
                cntNext   = '0;
                toCntNext = '0;
            end
        endcase
    end

    assign fifoPush = (state == RxCheck) && frameOk;
    assign kb_ready = !fifoEmpty;

    // A push into a full FIFO survives only if a pop frees a slot in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (fifoPush && fifoFull && !(sig_rd_kb && !fifoEmpty)) begin
            overflow <= 1'b1;
        end
    end

    kbd_fifo #(
        .WIDTH (KB_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifoPush),
        .pushData (shifted[KB_WIDTH:1] & '0 | frame[KB_WIDTH-1:0]),
        .pop      (sig_rd_kb),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .head     (kb_rdata)
    );

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- PS/2 keyboard receiver and scancode buffer. It is the device-side responder for the CPU keyboard MMIO read path.
- Samples the external PS/2 clock/data lines, deframes 11-bit scancode frames, and checks them.
- Queues good scancodes in a small FIFO.
- Presents the FIFO head to the MMIO decoder as kb_rdata/kb_ready. Pops one entry per sig_rd_kb strobe.

Parameters:
KB_WIDTH, 8, scancode width; equals `KbWidth
FIFO_DEPTH, 8, scancode entries; power of two, >= 2
TIMEOUT, 20000, clk cycles without a PS/2 falling edge before a partial frame is aborted

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ps2_clk  input  1  raw PS/2 clock from pad (asynchronous)
ps2_data  input  1  raw PS/2 data from pad (asynchronous)
sig_rd_kb  input  1  read strobe from MMIO decoder; pops FIFO head at posedge clk
kb_rdata  output  KB_WIDTH  FIFO head scancode (combinational from storage); 0 when empty
kb_ready  output  1  FIFO non-empty
overflow  output  1  sticky: a good frame was dropped because the FIFO was full
frame_err  output  1  one-cycle pulse per rejected frame (start/stop/parity/timeout)

Behaviour:
- Reset: one clock; rst is synchronous and active-high, sampled at posedge clk. On reset:
  - all registers clear; FIFO empty; kb_ready=0, kb_rdata=0, overflow=0, frame_err=0;
  - receiver state to IDLE, bit count 0, timeout counter 0;
  - synchronizer flops set to 1 (bus idle).
  - Reset mid-frame discards the partial frame; no error pulse is raised.
- Input sync: each of ps2_clk and ps2_data passes through a 2-flop synchronizer.
- Edge detect: fall = prev_sync_clk & ~sync_clk. All sampling of data happens only on fall, using sync_data.
- Receiver FSM:
  - IDLE: on fall with sync_data=0 (start bit), go to RECV with cnt=1. On fall with data=1, stay in IDLE (glitch ignored).
  - RECV: each fall shifts sync_data into the frame register LSB-first, and cnt increments.
    - When cnt reaches 10 and the stop bit is sampled on fall, go to CHECK.
    - The timeout counter resets on every fall. If it reaches TIMEOUT-1 while in RECV, return to IDLE and pulse frame_err.
  - CHECK (1 cycle):
    - valid = start==0 && stop==1 && (^data ^ parity)==1 (odd parity).
    - If valid, push data. If invalid, pulse frame_err in this cycle.
    - Always return to IDLE.
- FIFO:
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits; full/empty are derived from the pointer MSB compare.
  - Push takes effect at posedge. kb_ready rises the cycle after a push into an empty FIFO; there is no bypass.
  - Pop happens when sig_rd_kb && kb_ready at posedge. sig_rd_kb while empty is ignored, with no pointer change.
  - kb_rdata changes to the next entry in the cycle after a pop. Holding sig_rd_kb for N cycles pops up to N entries.
  - Simultaneous push and pop: both occur, and the count is unchanged.
  - When full, a push is accepted if a pop occurs in the same cycle. Otherwise the frame is dropped and overflow is set.
  - overflow clears only on rst.
- No transmit/host-to-device path. This block never drives ps2_clk or ps2_data.

Decomposition:
- `KbWidth, PS2 frame length (11) and the default timeout live in the shared defines include used by the CPU/MMIO files.
- One sub-module: kbd_fifo, a parameterised sync FIFO with push/pop/full/empty/head.
- The PS/2 deframer FSM stays in ps2_kbd_ctrl.

Test Plan:
1. Reset, then send frame 0x1C (start 0, data LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1) -> kb_ready=1 one cycle after CHECK, kb_rdata=0x1C, frame_err never pulses.
2. Send 0x1C, 0xF0 (parity 1), 0x1C, then strobe sig_rd_kb for 1 cycle three times -> reads 0x1C, 0xF0, 0x1C in order; kb_ready=0 after the third pop; a further strobe leaves state unchanged.
3. Send 0x1C with parity bit 1 -> frame_err pulses for exactly 1 cycle; kb_ready stays 0. Repeat with stop bit 0 -> same result.
4. Send 9 good frames (0x01..0x09) with no reads, FIFO_DEPTH=8 -> overflow=1, FIFO holds 0x01..0x08, 0x09 is lost. Then assert sig_rd_kb on the cycle CHECK pushes a 10th frame 0x0A -> push accepted, count stays 8.
5. Send start plus 4 data bits, then idle for TIMEOUT cycles -> frame_err pulses; the next complete frame 0x2A is received correctly.
6. Assert rst after 6 bits of a frame, release, then send 0x33 -> the partial frame is discarded, no frame_err, kb_rdata=0x33.
